// File: rtl/svsg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// segment lookup table, scan FSM states and segment bit positions.
package svsg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/svsg_seg_decode.sv
// Combinational hex nibble to seven-segment lookup with a forced-blank input.
module svsg_seg_decode
  import svsg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    if (blank_i) begin
      seg_o = 7'h00;
    end else begin
      seg_o = SEG_LUT[nibble_i];
    end
  end

endmodule

// File: rtl/svsg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: blank/show slots per digit,
// frame-synchronous digit update through a single pending register.
module svsg_scan_ctrl
  import svsg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int BLANK      = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    en,
  input  logic                    lzb_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int CNT_W = $clog2((PRESCALE > BLANK) ? PRESCALE : BLANK);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, shad_data_q, shad_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic                    pend_v_q, pend_v_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    fd_q, fd_d;
  logic                    boundary_s, accept_s, lz_blank_s;
  logic [3:0]              nib_s;
  logic [6:0]              seg7_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              fd_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // The first blank cycle of digit 0 is the only point where the shown set may change.
  assign boundary_s = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
  assign accept_s   = load_valid && !pend_v_q;

  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_v_d    = pend_v_q;
    shad_data_d = shad_data_q;
    shad_dp_d   = shad_dp_q;
    if (boundary_s && pend_v_q) begin
      shad_data_d = pend_data_q;
      shad_dp_d   = pend_dp_q;
      pend_v_d    = 1'b0;
    end else if (accept_s) begin
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
      pend_v_d    = 1'b1;
    end else begin
      pend_v_d = pend_v_q;
    end
  end

  // Outputs are computed from the next state so they register on the same edge as the FSM.
  assign nib_s = shad_data_d[{idx_d, 2'b00} +: 4];

  always_comb begin
    lz_blank_s = lzb_en && (idx_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_d)) && (shad_data_d[4*i +: 4] != 4'h0)) begin
        lz_blank_s = 1'b0;
      end
    end
  end

  svsg_seg_decode u_dec (
    .nibble_i (nib_s),
    .blank_i  (lz_blank_s),
    .seg_o    (seg7_s)
  );

  always_comb begin
    seg_d = 8'h00;
    dig_d = '0;
    if (state_d == ST_SHOW) begin
      seg_d[SEG_G:SEG_A] = seg7_s;
      seg_d[SEG_DP]      = shad_dp_d[idx_d] && !lz_blank_s;
      dig_d              = NUM_DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      shad_data_q <= '0;
      shad_dp_q   <= '0;
      seg_q       <= 8'h00;
      dig_q       <= '0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_v_q    <= pend_v_d;
      shad_data_q <= shad_data_d;
      shad_dp_q   <= shad_dp_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      fd_q        <= fd_d;
    end
  end

  assign seg_o      = seg_q;
  assign dig_o      = dig_q;
  assign frame_done = fd_q;
  assign busy       = (state_q != ST_IDLE);
  assign load_ready = !pend_v_q;

endmodule

// File: tb/tb_svsg_scan_ctrl.sv
// Bench for svsg_scan_ctrl: positional frame model checked every cycle plus
// directed scenarios with literal expected segment patterns.
`timescale 1ns/1ps
module tb_svsg_scan_ctrl;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + PS;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst, en, lzb_en, load_valid, load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [7:0]  seg_o;
  logic [3:0]  dig_o;
  logic        frame_done, busy;

  int total = 0;
  int bad   = 0;

  logic [6:0] hex7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  svsg_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK(BL)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en         (en),
    .lzb_en     (lzb_en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .seg_o      (seg_o),
    .dig_o      (dig_o),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pos = cycles since scanning started (-1 when dark/idle).
  int          pos = -1;
  logic [15:0] m_sh, m_pd;
  logic [3:0]  m_shdp, m_pddp;
  logic        m_pv;

  function automatic logic [7:0] model_seg(input int s);
    logic z;
    z = 1'b1;
    for (int k = s; k < ND; k++) begin
      if (m_sh[4*k +: 4] != 4'h0) z = 1'b0;
    end
    if (lzb_en && (s > 0) && z) return 8'h00;
    return {m_shdp[s], hex7[m_sh[4*s +: 4]]};
  endfunction

  initial begin
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_fd;
    int         slot;
    forever begin
      @(posedge clk);
      if (rst) begin
        pos = -1; m_pv = 1'b0;
        m_sh = 16'h0; m_shdp = 4'h0; m_pd = 16'h0; m_pddp = 4'h0;
      end else begin
        if (pos >= 0 && (pos % FRAME) == 0 && m_pv) begin
          m_sh = m_pd; m_shdp = m_pddp; m_pv = 1'b0;
        end else if (load_valid && !m_pv) begin
          m_pd = load_data; m_pddp = load_dp; m_pv = 1'b1;
        end
        pos = en ? pos + 1 : -1;
      end
      e_seg = 8'h00;
      e_dig = 4'h0;
      if (pos >= 0 && (pos % SLOT) >= BL) begin
        slot  = (pos % FRAME) / SLOT;
        e_dig = 4'(1 << slot);
        e_seg = model_seg(slot);
      end
      e_fd = (pos > 0) && ((pos % FRAME) == 0);
      #1;
      chk("seg_o", seg_o, e_seg);
      chk("dig_o", dig_o, e_dig);
      chk("frame_done", frame_done, e_fd);
      chk("busy", busy, pos >= 0);
      chk("load_ready", load_ready, !m_pv);
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    int n = 0;
    while (!load_ready && n < 100) begin
      @(negedge clk); n++;
    end
    load_data = d; load_dp = dp; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!frame_done && n < 100);
    chk("frame_done_seen", frame_done, 1'b1);
  endtask

  task automatic expect_digit(input int d, input logic [7:0] exp, input string name);
    int n = 0;
    logic [3:0] want;
    want = 4'(1 << d);
    do begin
      @(negedge clk); n++;
    end while (dig_o != want && n < 100);
    chk(name, {dig_o, seg_o}, {want, exp});
  endtask

  task automatic en_latency(input string name);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (dig_o == 4'h0 && n < 50);
    chk(name, n, 3);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; lzb_en = 1'b0;
    load_valid = 1'b0; load_data = 16'h0; load_dp = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_seg", seg_o, 8'h00);
    chk("rst_dig", dig_o, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_fd", frame_done, 1'b0);

    // Load while idle, then enable.
    do_load(16'h12F9, 4'h0);
    chk("idle_load_ready_low", load_ready, 1'b0);
    en = 1'b1;
    en_latency("en_latency");
    chk("f1_d0", {dig_o, seg_o}, {4'b0001, 8'h6F});
    expect_digit(1, 8'h71, "f1_d1");
    expect_digit(2, 8'h5B, "f1_d2");
    expect_digit(3, 8'h06, "f1_d3");
    wait_frame();
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!frame_done && n < 100);
    chk("frame_period", n, FRAME);

    // Leading-zero blanking on and off.
    lzb_en = 1'b1;
    do_load(16'h0070, 4'h0);
    wait_frame();
    wait_frame();
    expect_digit(0, 8'h3F, "lzb_d0");
    expect_digit(1, 8'h07, "lzb_d1");
    expect_digit(2, 8'h00, "lzb_d2");
    expect_digit(3, 8'h00, "lzb_d3");
    lzb_en = 1'b0;
    wait_frame();
    expect_digit(0, 8'h3F, "nolzb_d0");
    expect_digit(1, 8'h07, "nolzb_d1");
    expect_digit(2, 8'h3F, "nolzb_d2");
    expect_digit(3, 8'h3F, "nolzb_d3");

    // Back-to-back loads mid-frame: B must stall until the boundary.
    wait_frame();
    expect_digit(1, 8'h07, "pre_ab_d1");
    load_data = 16'hABCD; load_dp = 4'h0; load_valid = 1'b1;
    @(negedge clk);
    chk("ab_ready_low", load_ready, 1'b0);
    load_data = 16'h4321;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!load_ready && n < 100);
    @(negedge clk);
    load_valid = 1'b0;
    chk("b_in_pend", load_ready, 1'b0);
    expect_digit(0, 8'h5E, "a_d0");
    expect_digit(1, 8'h39, "a_d1");
    expect_digit(2, 8'h7C, "a_d2");
    expect_digit(3, 8'h77, "a_d3");
    wait_frame();
    expect_digit(0, 8'h06, "b_d0");
    expect_digit(1, 8'h5B, "b_d1");
    expect_digit(2, 8'h4F, "b_d2");
    expect_digit(3, 8'h66, "b_d3");

    // Decimal-point mask.
    do_load(16'h8888, 4'b0100);
    wait_frame();
    wait_frame();
    expect_digit(0, 8'h7F, "dp_d0");
    expect_digit(1, 8'h7F, "dp_d1");
    expect_digit(2, 8'hFF, "dp_d2");

    // Drop enable during digit 2, then restart.
    en = 1'b0;
    @(negedge clk);
    chk("endrop_seg", seg_o, 8'h00);
    chk("endrop_dig", dig_o, 4'h0);
    chk("endrop_busy", busy, 1'b0);
    en = 1'b1;
    en_latency("reen_latency");
    chk("reen_d0", {dig_o, seg_o}, {4'b0001, 8'h7F});

    // Reset mid-frame with a load pending.
    expect_digit(1, 8'h7F, "prerst_d1");
    do_load(16'h5555, 4'h0);
    chk("prerst_pend", load_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_seg", seg_o, 8'h00);
    chk("midrst_dig", dig_o, 4'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", load_ready, 1'b1);
    rst = 1'b0;
    expect_digit(0, 8'h3F, "postrst_d0");
    expect_digit(3, 8'h3F, "postrst_d3");
    wait_frame();
    expect_digit(0, 8'h3F, "postrst_nopend_d0");

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
